// File: rtl/macc_pkg.sv
// Shared encodings for the matrix write path.
// Matrix select codes, loader states and default widths.
package macc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 10;

    localparam logic [1:0] MSEL_C = 2'd0;
    localparam logic [1:0] MSEL_B = 2'd1;
    localparam logic [1:0] MSEL_A = 2'd2;
    localparam logic [1:0] MSEL_X = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    function automatic logic [2:0] sel_onehot(input logic [1:0] s);
        return 3'b001 << s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small pointer-based synchronous FIFO.
// Extra pointer bit distinguishes full from empty.
module sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/matrix_loader.sv
// Streams PS words into one target matrix via a skid FIFO.
// Counts rows/columns to detect the end of the load.
module matrix_loader
    import macc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_L,
    input  logic              VDD,
    input  logic              GND,
    input  logic              start,
    input  logic [1:0]        sel,
    input  logic [CNT_W-1:0]  max_col_count,
    input  logic [CNT_W-1:0]  max_row_count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              dst_hold,
    output logic [2:0]        wen,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ld_state_e         state_q;
    ld_state_e         state_d;
    logic [1:0]        sel_q;
    logic [CNT_W-1:0]  max_col_q;
    logic [CNT_W-1:0]  max_row_q;
    logic [CNT_W-1:0]  col_q;
    logic [CNT_W-1:0]  row_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              push;
    logic              pop;
    logic              last_word;
    logic              go;
    logic              unused_supply;

    assign unused_supply = VDD ^ GND;

    assign push      = s_valid && s_ready;
    assign last_word = (row_q == max_row_q) &&
                       (col_q == max_col_q);
    assign pop       = !fifo_empty && !dst_hold &&
                       (state_q == ST_LOAD ||
                        state_q == ST_DRAIN);
    assign go        = (state_q == ST_IDLE) && start;

    sync_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (CLK),
        .rst_n(RST_L),
        .push (push),
        .pop  (pop),
        .wdata(s_data),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && sel != MSEL_X)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = !fifo_full;
                busy    = 1'b1;
                if (push && last_word)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // wait for the final write to leave the pipeline
                if (fifo_empty && wen == 3'b000)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            sel_q     <= MSEL_C;
            max_col_q <= '0;
            max_row_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            err       <= 1'b0;
        end else if (go) begin
            if (sel == MSEL_X) begin
                err <= 1'b1;
            end else begin
                sel_q     <= sel;
                max_col_q <= max_col_count;
                max_row_q <= max_row_count;
                col_q     <= '0;
                row_q     <= '0;
                err       <= 1'b0;
            end
        end else if (push) begin
            if (s_last != last_word)
                err <= 1'b1;
            if (col_q == max_col_q) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            wen  <= 3'b000;
            dout <= '0;
        end else if (pop) begin
            wen  <= sel_onehot(sel_q);
            dout <= fifo_rdata;
        end else begin
            wen  <= 3'b000;
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: stimulus queues expected
// writes, a negedge monitor pops and compares them.
module tb_matrix_loader;

    logic        CLK;
    logic        RST_L;
    logic        VDD;
    logic        GND;
    logic        start;
    logic [1:0]  sel;
    logic [9:0]  max_col_count;
    logic [9:0]  max_row_count;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        dst_hold;
    logic [2:0]  wen;
    logic [31:0] dout;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [2:0]  w;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;
    int   n_done;
    bit   lat_arm;
    time  t_acc;
    time  t_first_wen;
    time  t_last_wen;

    matrix_loader dut (
        .CLK          (CLK),
        .RST_L        (RST_L),
        .VDD          (VDD),
        .GND          (GND),
        .start        (start),
        .sel          (sel),
        .max_col_count(max_col_count),
        .max_row_count(max_row_count),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .dst_hold     (dst_hold),
        .wen          (wen),
        .dout         (dout),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_L) begin
            if (done)
                n_done++;
            if (wen != 3'b000) begin
                t_last_wen = $time;
                if (lat_arm) begin
                    t_first_wen = $time;
                    lat_arm     = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: wen %b dout %0h",
                             wen, dout);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wen", 64'(wen), 64'(e.w));
                    chk("dout", 64'(dout), 64'(e.d));
                end
            end
        end
    end

    task automatic do_start(input logic [1:0] s,
                            input logic [9:0] mr,
                            input logic [9:0] mc);
        start         = 1'b1;
        sel           = s;
        max_row_count = mr;
        max_col_count = mc;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t;
        t       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            @(negedge CLK);
            if (s_ready) begin
                @(posedge CLK);
                t_acc = $time;
                #1;
                break;
            end
            t++;
            if (t > 50) begin
                n_vec++;
                n_bad++;
                $display("FAIL send_timeout: word %0h never accepted", d);
                break;
            end
        end
    endtask

    task automatic expect_w(input logic [1:0] s, input logic [31:0] d);
        exp_t e;
        e.w = 3'b001 << s;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge CLK);
            t++;
        end
        chk(nm, 64'(done), 64'd1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int   d0;
        time  t_first_acc;
        n_vec         = 0;
        n_bad         = 0;
        n_done        = 0;
        lat_arm       = 1'b0;
        VDD           = 1'b1;
        GND           = 1'b0;
        RST_L         = 1'b0;
        start         = 1'b0;
        sel           = 2'd0;
        max_col_count = '0;
        max_row_count = '0;
        s_valid       = 1'b0;
        s_data        = '0;
        s_last        = 1'b0;
        dst_hold      = 1'b0;
        #3;
        chk("rst_s_ready", 64'(s_ready), 0);
        chk("rst_wen", 64'(wen), 0);
        chk("rst_dout", 64'(dout), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        #9 RST_L = 1'b1;
        idle_cycles(1);

        // 1: A, 2x2, back-to-back
        d0      = n_done;
        lat_arm = 1'b1;
        do_start(2'd2, 10'd1, 10'd1);
        chk("t1_busy", 64'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = 32'h11 * (i + 1);
            expect_w(2'd2, w);
            send(w, i == 3);
            if (i == 0)
                t_first_acc = t_acc;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t1_done");
        chk("t1_latency", 64'(t_first_wen - t_first_acc), 15);
        chk("t1_span", 64'(t_last_wen - t_first_wen), 30);
        chk("t1_done_cnt", 64'(n_done - d0), 1);
        chk("t1_err", 64'(err), 0);
        chk("t1_busy_end", 64'(busy), 0);
        chk("t1_drained", 64'(exp_q.size()), 0);

        // 2: B, 1x8, held until the FIFO fills
        d0       = n_done;
        dst_hold = 1'b1;
        do_start(2'd1, 10'd0, 10'd7);
        for (int i = 0; i < 8; i++) begin
            expect_w(2'd1, 32'hB0 + i);
            send(32'hB0 + i, i == 7);
        end
        s_valid = 1'b1;
        s_data  = 32'hBAD;
        @(negedge CLK);
        chk("t2_full_ready", 64'(s_ready), 0);
        chk("t2_hold_wen", 64'(wen), 0);
        idle_cycles(3);
        s_valid = 1'b0;
        chk("t2_hold_wen2", 64'(wen), 0);
        chk("t2_busy", 64'(busy), 1);
        dst_hold = 1'b0;
        wait_done("t2_done");
        chk("t2_done_cnt", 64'(n_done - d0), 1);
        chk("t2_drained", 64'(exp_q.size()), 0);
        chk("t2_err", 64'(err), 0);

        // 3: C, 2x2, early s_last
        d0 = n_done;
        do_start(2'd0, 10'd1, 10'd1);
        for (int i = 0; i < 4; i++) begin
            expect_w(2'd0, 32'hC0 + i);
            send(32'hC0 + i, i == 1);
            if (i == 0)
                chk("t3_err_pre", 64'(err), 0);
            if (i == 1)
                chk("t3_err_set", 64'(err), 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t3_done");
        chk("t3_done_cnt", 64'(n_done - d0), 1);
        chk("t3_err_sticky", 64'(err), 1);
        chk("t3_drained", 64'(exp_q.size()), 0);

        // 6: restart during LOAD is ignored; start clears err
        d0 = n_done;
        do_start(2'd2, 10'd0, 10'd1);
        chk("t6_err_clr", 64'(err), 0);
        expect_w(2'd2, 32'hD1);
        send(32'hD1, 1'b0);
        s_valid = 1'b0;
        do_start(2'd0, 10'd5, 10'd5);
        expect_w(2'd2, 32'hD2);
        send(32'hD2, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t6_done");
        chk("t6_done_cnt", 64'(n_done - d0), 1);
        chk("t6_err", 64'(err), 0);
        chk("t6_drained", 64'(exp_q.size()), 0);

        // 4: illegal select
        do_start(2'd3, 10'd0, 10'd0);
        chk("t4_err", 64'(err), 1);
        chk("t4_busy", 64'(busy), 0);
        chk("t4_ready", 64'(s_ready), 0);
        idle_cycles(5);
        chk("t4_busy2", 64'(busy), 0);

        // 5: reset mid-load
        dst_hold = 1'b1;
        do_start(2'd2, 10'd1, 10'd1);
        send(32'hE1, 1'b0);
        send(32'hE2, 1'b0);
        s_valid = 1'b0;
        @(negedge CLK);
        #2 RST_L = 1'b0;
        #1;
        chk("t5_s_ready", 64'(s_ready), 0);
        chk("t5_wen", 64'(wen), 0);
        chk("t5_dout", 64'(dout), 0);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_done", 64'(done), 0);
        chk("t5_err", 64'(err), 0);
        #4 RST_L = 1'b1;
        dst_hold = 1'b0;
        idle_cycles(10);
        chk("t5_busy_post", 64'(busy), 0);
        chk("t5_ready_post", 64'(s_ready), 0);
        d0 = n_done;
        do_start(2'd1, 10'd0, 10'd0);
        expect_w(2'd1, 32'hF1);
        send(32'hF1, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t5_recover_done");
        chk("t5_done_cnt", 64'(n_done - d0), 1);
        chk("final_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
